reg_pair_sequencer: RTL and testbench

- Controller that owns the single write port of the 8-bit CPU register file (B,C,D,E,H,L,A plus a read-as-zero slot at index 6).
- Runs 16-bit register-pair operations (load, increment, decrement, read) as sequenced low-byte then high-byte writes.
- Arbitrates that write port against a single-byte write requester from the instruction decoder.
- Sits between decode/execute control and the register file: drives its read selects, write data, write select and write enable.

---
 rtl/reg_pair_sequencer_pkg.sv | 56 +++++
 rtl/reg_pair_sequencer_if.sv | 50 +++++
 rtl/reg_pair_sequencer.sv | 164 ++++++++++++++++
 tb/tb_reg_pair_sequencer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pair_sequencer_pkg.sv
// Package reg_file_pkg: shared definitions for the register-pair sequencer.
//   - op_e       : pair operation codes (LOAD, INC, DEC, READ)
//   - pair_e     : register-pair codes (BC, DE, HL, AZ)
//   - IDX_*      : 8-bit register-file indices (slot 6 reads as zero)
//   - state_e    : sequencer states
//   - pair_to_idx: maps a pair code to its {hi, lo} register indices
package reg_file_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2,
    OP_READ = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    PAIR_BC = 2'd0,
    PAIR_DE = 2'd1,
    PAIR_HL = 2'd2,
    PAIR_AZ = 2'd3
  } pair_e;

  localparam logic [2:0] IDX_B    = 3'd0;
  localparam logic [2:0] IDX_C    = 3'd1;
  localparam logic [2:0] IDX_D    = 3'd2;
  localparam logic [2:0] IDX_E    = 3'd3;
  localparam logic [2:0] IDX_H    = 3'd4;
  localparam logic [2:0] IDX_L    = 3'd5;
  localparam logic [2:0] IDX_ZERO = 3'd6;
  localparam logic [2:0] IDX_A    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_LO,
    ST_WR_HI,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [2:0] hi;
    logic [2:0] lo;
  } pair_idx_t;

  // AZ pairs A (high) with the read-as-zero slot (low).
  function automatic pair_idx_t pair_to_idx(input pair_e pair);
    pair_idx_t idx;
    case (pair)
      PAIR_BC: idx = '{hi: IDX_B, lo: IDX_C};
      PAIR_DE: idx = '{hi: IDX_D, lo: IDX_E};
      PAIR_HL: idx = '{hi: IDX_H, lo: IDX_L};
      default: idx = '{hi: IDX_A, lo: IDX_ZERO};
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/reg_pair_sequencer_if.sv
// Interface reg_pair_sequencer_if: bundles the pair-request, response,
// byte-write and register-file signals of reg_pair_sequencer.
//   master : requester / register-file side (drives requests and read data)
//   slave  : sequencer side (drives readies, response and register-file controls)
// Optional macro REG_PAIR_SEQ_WRAP_FLAG_EN adds resp_wrap.
interface reg_pair_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_pair;
  logic [15:0] req_data;
  logic        resp_valid;
  logic [15:0] resp_data;
`ifdef REG_PAIR_SEQ_WRAP_FLAG_EN
  logic        resp_wrap;
`endif
  logic        byte_wr_valid;
  logic        byte_wr_ready;
  logic [2:0]  byte_wr_sel;
  logic [7:0]  byte_wr_data;
  logic [2:0]  rf_out1_sel;
  logic [2:0]  rf_out2_sel;
  logic [7:0]  rf_out1;
  logic [7:0]  rf_out2;
  logic [7:0]  rf_data_in;
  logic [2:0]  rf_data_in_sel;
  logic        rf_write_reg;

  modport master (
    output req_valid, req_op, req_pair, req_data,
    output byte_wr_valid, byte_wr_sel, byte_wr_data,
    output rf_out1, rf_out2,
    input  req_ready, resp_valid, resp_data, byte_wr_ready,
    input  rf_out1_sel, rf_out2_sel, rf_data_in, rf_data_in_sel, rf_write_reg
`ifdef REG_PAIR_SEQ_WRAP_FLAG_EN
    , input resp_wrap
`endif
  );

  modport slave (
    input  req_valid, req_op, req_pair, req_data,
    input  byte_wr_valid, byte_wr_sel, byte_wr_data,
    input  rf_out1, rf_out2,
    output req_ready, resp_valid, resp_data, byte_wr_ready,
    output rf_out1_sel, rf_out2_sel, rf_data_in, rf_data_in_sel, rf_write_reg
`ifdef REG_PAIR_SEQ_WRAP_FLAG_EN
    , output resp_wrap
`endif
  );
endinterface

// File: rtl/reg_pair_sequencer.sv
// reg_pair_sequencer: owns the single write port of the 8-bit register file.
// Runs 16-bit pair operations (LOAD/INC/DEC/READ) as a low-byte write then a
// high-byte write, and arbitrates the port against single-byte writes.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : reg_pair_sequencer_if.slave (request/response, byte write,
//           register-file read selects/data and write controls)
// Parameter BYTE_PRIORITY: 1 = byte write wins in IDLE, 0 = pair request wins.
// Optional macro REG_PAIR_SEQ_WRAP_FLAG_EN adds resp_wrap (INC/DEC wrap flag).
module reg_pair_sequencer
  import reg_file_pkg::*;
#(
  parameter bit BYTE_PRIORITY = 1'b1
) (
  input logic                 clock,
  input logic                 reset,
  reg_pair_sequencer_if.slave bus
);

  state_e      r_state;
  state_e      w_next_state;
  op_e         r_op;
  pair_e       r_pair;
  logic [15:0] r_result;

  op_e         w_req_op;
  pair_e       w_req_pair;
  pair_idx_t   w_cap_idx;
  pair_idx_t   w_rd_idx;
  logic [15:0] w_cur;
  logic [15:0] w_new_result;
  logic        w_req_ready;
  logic        w_byte_ready;
  logic        w_accept;
  logic        w_we;
  logic [2:0]  w_wsel;
  logic [7:0]  w_wdata;
  logic        w_resp_valid;

  assign w_req_op   = op_e'(bus.req_op);
  assign w_req_pair = pair_e'(bus.req_pair);
  assign w_cap_idx  = pair_to_idx(r_pair);
  assign w_cur      = {bus.rf_out1, bus.rf_out2};
  assign w_accept   = bus.req_valid && w_req_ready;

  // In IDLE the read selects follow req_pair, so w_cur already holds the
  // requested pair's current value in the accept cycle.
  always_comb begin
    case (w_req_op)
      OP_LOAD: w_new_result = bus.req_data;
      OP_INC:  w_new_result = w_cur + 16'd1;
      OP_DEC:  w_new_result = w_cur - 16'd1;
      default: w_new_result = w_cur;
    endcase
  end

`ifdef REG_PAIR_SEQ_WRAP_FLAG_EN
  logic r_wrap;
  logic w_new_wrap;

  assign w_new_wrap = ((w_req_op == OP_INC) && (w_cur == '1)) ||
                      ((w_req_op == OP_DEC) && (w_cur == '0));
  assign bus.resp_wrap = w_resp_valid & r_wrap;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrap <= 1'b0;
    end else if (w_accept) begin
      r_wrap <= w_new_wrap;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_LOAD;
      r_pair   <= PAIR_BC;
      r_result <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_op     <= w_req_op;
        r_pair   <= w_req_pair;
        r_result <= w_new_result;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_req_ready  = 1'b0;
    w_byte_ready = 1'b0;
    w_we         = 1'b0;
    w_wsel       = '0;
    w_wdata      = '0;
    w_resp_valid = 1'b0;
    w_rd_idx     = w_cap_idx;

    case (r_state)
      ST_IDLE: begin
        w_rd_idx = pair_to_idx(w_req_pair);
        if (BYTE_PRIORITY) begin
          w_byte_ready = 1'b1;
          w_req_ready  = !bus.byte_wr_valid;
        end else begin
          w_req_ready  = 1'b1;
          w_byte_ready = !bus.req_valid;
        end
        if (bus.req_valid && w_req_ready) begin
          w_next_state = (w_req_op == OP_READ) ? ST_DONE : ST_WR_LO;
        end
        if (bus.byte_wr_valid && w_byte_ready) begin
          w_we    = 1'b1;
          w_wsel  = bus.byte_wr_sel;
          w_wdata = bus.byte_wr_data;
        end
      end
      // READ never enters the write states; the op gate keeps the port
      // quiet even if it somehow did.
      ST_WR_LO: begin
        w_we         = (r_op != OP_READ);
        w_wsel       = w_cap_idx.lo;
        w_wdata      = r_result[7:0];
        w_next_state = ST_WR_HI;
      end
      ST_WR_HI: begin
        w_we         = (r_op != OP_READ);
        w_wsel       = w_cap_idx.hi;
        w_wdata      = r_result[15:8];
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_resp_valid = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase

    // Hold every combinational output at its reset value while reset is
    // asserted, including the IDLE decode of req_pair.
    if (reset) begin
      w_req_ready  = 1'b0;
      w_byte_ready = 1'b0;
      w_we         = 1'b0;
      w_wsel       = '0;
      w_wdata      = '0;
      w_resp_valid = 1'b0;
      w_rd_idx     = '0;
    end
  end

  assign bus.req_ready      = w_req_ready;
  assign bus.byte_wr_ready  = w_byte_ready;
  assign bus.resp_valid     = w_resp_valid;
  assign bus.resp_data      = w_resp_valid ? r_result : '0;
  assign bus.rf_out1_sel    = w_rd_idx.hi;
  assign bus.rf_out2_sel    = w_rd_idx.lo;
  assign bus.rf_write_reg   = w_we;
  assign bus.rf_data_in_sel = w_wsel;
  assign bus.rf_data_in     = w_wdata;

endmodule

// File: tb/tb_reg_pair_sequencer.sv
// Self-checking bench for reg_pair_sequencer: one byte-priority instance
// checked every cycle against an architectural model, plus a pair-priority
// instance exercised with directed literal expectations.
module tb_reg_pair_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  reg_pair_sequencer_if bus ();
  reg_pair_sequencer_if bus0 ();

  reg_pair_sequencer #(.BYTE_PRIORITY(1'b1)) dut (
    .clock(clk), .reset(rst), .bus(bus)
  );
  reg_pair_sequencer #(.BYTE_PRIORITY(1'b0)) dut0 (
    .clock(clk), .reset(rst), .bus(bus0)
  );

  // Register files: slot 6 ignores writes and reads as zero; no reset.
  logic [7:0] rf   [8] = '{default: 8'h00};
  logic [7:0] rf0  [8] = '{default: 8'h00};
  logic [7:0] gold [8] = '{default: 8'h00};

  always @(posedge clk) begin
    if (bus.rf_write_reg && bus.rf_data_in_sel != 3'd6) rf[bus.rf_data_in_sel] <= bus.rf_data_in;
    if (bus0.rf_write_reg && bus0.rf_data_in_sel != 3'd6) rf0[bus0.rf_data_in_sel] <= bus0.rf_data_in;
  end
  assign bus.rf_out1  = rf[bus.rf_out1_sel];
  assign bus.rf_out2  = rf[bus.rf_out2_sel];
  assign bus0.rf_out1 = rf0[bus0.rf_out1_sel];
  assign bus0.rf_out2 = rf0[bus0.rf_out2_sel];

  // Architectural model of the byte-priority instance.
  localparam logic [2:0] HI_OF [4] = '{3'd0, 3'd2, 3'd4, 3'd7};
  localparam logic [2:0] LO_OF [4] = '{3'd1, 3'd3, 3'd5, 3'd6};

  bit          m_pend = 1'b0;
  int          m_left = 0;
  bit          m_isread = 1'b0;
  logic [15:0] m_res = '0;
  logic [2:0]  m_hi = '0;
  logic [2:0]  m_lo = '0;
`ifdef REG_PAIR_SEQ_WRAP_FLAG_EN
  bit          m_wrap = 1'b0;
`endif

  function automatic logic [15:0] model_result(input logic [1:0] op, input logic [15:0] cur,
                                               input logic [15:0] imm);
    case (op)
      2'd0:    return imm;
      2'd1:    return cur + 16'd1;
      2'd2:    return cur - 16'd1;
      default: return cur;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 1'b0;
      m_left <= 0;
    end else if (m_pend) begin
      if (!m_isread && m_left == 3 && m_lo != 3'd6) gold[m_lo] <= m_res[7:0];
      if (!m_isread && m_left == 2) gold[m_hi] <= m_res[15:8];
      m_left <= m_left - 1;
      m_pend <= (m_left > 1);
    end else begin
      if (bus.byte_wr_valid && bus.byte_wr_sel != 3'd6) gold[bus.byte_wr_sel] <= bus.byte_wr_data;
      if (bus.req_valid && !bus.byte_wr_valid) begin
        m_pend   <= 1'b1;
        m_left   <= (bus.req_op == 2'd3) ? 1 : 3;
        m_isread <= (bus.req_op == 2'd3);
        m_hi     <= HI_OF[bus.req_pair];
        m_lo     <= LO_OF[bus.req_pair];
        m_res    <= model_result(bus.req_op,
                                 {gold[HI_OF[bus.req_pair]], gold[LO_OF[bus.req_pair]]},
                                 bus.req_data);
`ifdef REG_PAIR_SEQ_WRAP_FLAG_EN
        m_wrap   <= (bus.req_op == 2'd1 &&
                     {gold[HI_OF[bus.req_pair]], gold[LO_OF[bus.req_pair]]} == 16'hFFFF) ||
                    (bus.req_op == 2'd2 &&
                     {gold[HI_OF[bus.req_pair]], gold[LO_OF[bus.req_pair]]} == 16'h0000);
`endif
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [63:0] a;
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_write_reg", bus.rf_write_reg, 0);
        chk("rst_data_in", bus.rf_data_in, 0);
        chk("rst_data_in_sel", bus.rf_data_in_sel, 0);
        chk("rst_out1_sel", bus.rf_out1_sel, 0);
        chk("rst_out2_sel", bus.rf_out2_sel, 0);
`ifdef REG_PAIR_SEQ_WRAP_FLAG_EN
        chk("rst_resp_wrap", bus.resp_wrap, 0);
`endif
      end else begin
        chk("resp_valid", bus.resp_valid, m_pend && m_left == 1);
        if (m_pend && m_left == 1) begin
          chk("resp_data", bus.resp_data, m_res);
`ifdef REG_PAIR_SEQ_WRAP_FLAG_EN
          chk("resp_wrap", bus.resp_wrap, m_wrap);
`endif
        end
        chk("req_ready", bus.req_ready, !m_pend && !bus.byte_wr_valid);
        chk("byte_wr_ready", bus.byte_wr_ready, !m_pend);
        if (m_pend) begin
          chk("busy_out1_sel", bus.rf_out1_sel, m_hi);
          chk("busy_out2_sel", bus.rf_out2_sel, m_lo);
          if (!m_isread && m_left >= 2) begin
            chk("pair_write_en", bus.rf_write_reg, 1);
            chk("pair_write_sel", bus.rf_data_in_sel, (m_left == 3) ? m_lo : m_hi);
            chk("pair_write_data", bus.rf_data_in, (m_left == 3) ? m_res[7:0] : m_res[15:8]);
          end else begin
            chk("no_write", bus.rf_write_reg, 0);
          end
        end else begin
          chk("idle_out1_sel", bus.rf_out1_sel, HI_OF[bus.req_pair]);
          chk("idle_out2_sel", bus.rf_out2_sel, LO_OF[bus.req_pair]);
          chk("idle_write_en", bus.rf_write_reg, bus.byte_wr_valid);
          if (bus.byte_wr_valid) begin
            chk("byte_write_sel", bus.rf_data_in_sel, bus.byte_wr_sel);
            chk("byte_write_data", bus.rf_data_in, bus.byte_wr_data);
          end
        end
        for (int i = 0; i < 8; i++) begin
          a[i*8 +: 8] = rf[i];
          e[i*8 +: 8] = gold[i];
        end
        chk("rf_contents", a, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic byte_wr(input logic [2:0] sel, input logic [7:0] data);
    bit ok = 1'b0;
    bus.byte_wr_valid = 1'b1;
    bus.byte_wr_sel   = sel;
    bus.byte_wr_data  = data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.byte_wr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("byte_accept", ok, 1);
    step();
    bus.byte_wr_valid = 1'b0;
  endtask

  // Issues one pair request; returns at the negedge of the response cycle.
  task automatic run_req(input logic [1:0] op, input logic [1:0] pair, input logic [15:0] data,
                         output int acc_wait, output int lat, output int nwr,
                         output logic [15:0] rd);
    bit ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_pair  = pair;
    bus.req_data  = data;
    acc_wait = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        acc_wait = i;
        break;
      end
    end
    chk("req_accept", ok, 1);
    step();
    bus.req_valid = 1'b0;
    lat = 0;
    nwr = 0;
    rd  = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.rf_write_reg) nwr++;
      if (bus.resp_valid) begin
        lat = k;
        rd  = bus.resp_data;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int aw, lat, nwr;
    logic [15:0] rd;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_pair = '0; bus.req_data = '0;
    bus.byte_wr_valid = 1'b0; bus.byte_wr_sel = '0; bus.byte_wr_data = '0;
    bus0.req_valid = 1'b0; bus0.req_op = '0; bus0.req_pair = '0; bus0.req_data = '0;
    bus0.byte_wr_valid = 1'b0; bus0.byte_wr_sel = '0; bus0.byte_wr_data = '0;
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    chk("reset_req_ready", bus.req_ready, 0);
    chk("reset_out2_sel", bus.rf_out2_sel, 3'd0);
    step();
    rst = 1'b0;

    // Preload B=01 C=00 H=FF L=FF A=12; a write to slot 6 is discarded.
    byte_wr(3'd0, 8'h01);
    byte_wr(3'd4, 8'hFF);
    byte_wr(3'd5, 8'hFF);
    byte_wr(3'd7, 8'h12);
    byte_wr(3'd6, 8'hAA);
    chk("zero_slot_kept", rf[6], 8'h00);

    run_req(2'd0, 2'd1, 16'hBEEF, aw, lat, nwr, rd);
    chk("load_de_latency", lat, 3);
    chk("load_de_data", rd, 16'hBEEF);
    chk("load_de_writes", nwr, 2);
    chk("load_de_D", rf[2], 8'hBE);
    chk("load_de_E", rf[3], 8'hEF);

    step();
    run_req(2'd1, 2'd2, 16'h0000, aw, lat, nwr, rd);
    chk("inc_hl_latency", lat, 3);
    chk("inc_hl_data", rd, 16'h0000);
    chk("inc_hl_H", rf[4], 8'h00);
    chk("inc_hl_L", rf[5], 8'h00);
`ifdef REG_PAIR_SEQ_WRAP_FLAG_EN
    chk("inc_hl_wrap", bus.resp_wrap, 1);
`endif

    step();
    run_req(2'd2, 2'd0, 16'h0000, aw, lat, nwr, rd);
    chk("dec_bc_data", rd, 16'h00FF);
    chk("dec_bc_B", rf[0], 8'h00);
    chk("dec_bc_C", rf[1], 8'hFF);
`ifdef REG_PAIR_SEQ_WRAP_FLAG_EN
    chk("dec_bc_wrap", bus.resp_wrap, 0);
`endif

    step();
    run_req(2'd0, 2'd0, 16'h1234, aw, lat, nwr, rd);
    step();
    run_req(2'd3, 2'd0, 16'h0000, aw, lat, nwr, rd);
    chk("read_bc_latency", lat, 1);
    chk("read_bc_writes", nwr, 0);
    chk("read_bc_data", rd, 16'h1234);

    step();
    run_req(2'd1, 2'd3, 16'h0000, aw, lat, nwr, rd);
    chk("inc_az_latency", lat, 3);
    chk("inc_az_data", rd, 16'h1201);
    chk("inc_az_A", rf[7], 8'h12);
    chk("inc_az_zero", rf[6], 8'h00);

    // Byte write and INC DE together: the byte write wins, INC follows.
    step();
    bus.byte_wr_valid = 1'b1; bus.byte_wr_sel = 3'd7; bus.byte_wr_data = 8'h55;
    bus.req_valid = 1'b1; bus.req_op = 2'd1; bus.req_pair = 2'd1;
    @(negedge clk);
    chk("prio1_req_ready", bus.req_ready, 0);
    chk("prio1_byte_ready", bus.byte_wr_ready, 1);
    step();
    bus.byte_wr_valid = 1'b0;
    run_req(2'd1, 2'd1, 16'h0000, aw, lat, nwr, rd);
    chk("prio1_accept_wait", aw, 1);
    chk("prio1_inc_de", rd, 16'hBEF0);
    chk("prio1_A", rf[7], 8'h55);

    // Byte write held while INC BC is busy.
    step();
    bus.req_valid = 1'b1; bus.req_op = 2'd1; bus.req_pair = 2'd0;
    @(negedge clk);
    chk("busy_req_ready", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    bus.byte_wr_valid = 1'b1; bus.byte_wr_sel = 3'd0; bus.byte_wr_data = 8'h77;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("busy_byte_ready", bus.byte_wr_ready, 0);
      if (k == 3) begin
        chk("busy_resp_valid", bus.resp_valid, 1);
        chk("busy_resp_data", bus.resp_data, 16'h1235);
      end
    end
    @(negedge clk);
    chk("busy_idle_byte_ready", bus.byte_wr_ready, 1);
    step();
    bus.byte_wr_valid = 1'b0;
    @(negedge clk);
    chk("busy_B", rf[0], 8'h77);
    chk("busy_C", rf[1], 8'h35);

    // Reset during WR_HI of LOAD BC 0xA1B2.
    step();
    bus.req_valid = 1'b1; bus.req_op = 2'd0; bus.req_pair = 2'd0; bus.req_data = 16'hA1B2;
    @(negedge clk);
    chk("abort_req_ready", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_C", rf[1], 8'hB2);
    chk("abort_B", rf[0], 8'h77);
    chk("abort_resp_valid", bus.resp_valid, 0);
    chk("abort_write_reg", bus.rf_write_reg, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", bus.req_ready, 1);
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_resp", bus.resp_valid, 0);
    end
    chk("abort_B_held", rf[0], 8'h77);

    // Pair-priority instance: INC DE wins, byte write stalls until IDLE.
    step();
    bus0.req_valid = 1'b1; bus0.req_op = 2'd1; bus0.req_pair = 2'd1;
    bus0.byte_wr_valid = 1'b1; bus0.byte_wr_sel = 3'd7; bus0.byte_wr_data = 8'h55;
    @(negedge clk);
    chk("prio0_req_ready", bus0.req_ready, 1);
    chk("prio0_byte_ready", bus0.byte_wr_ready, 0);
    chk("prio0_no_write", bus0.rf_write_reg, 0);
    step();
    bus0.req_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("prio0_busy_byte_ready", bus0.byte_wr_ready, 0);
      if (k == 3) begin
        chk("prio0_resp_valid", bus0.resp_valid, 1);
        chk("prio0_resp_data", bus0.resp_data, 16'h0001);
        chk("prio0_A_pending", rf0[7], 8'h00);
      end
    end
    @(negedge clk);
    chk("prio0_idle_byte_ready", bus0.byte_wr_ready, 1);
    chk("prio0_idle_write_en", bus0.rf_write_reg, 1);
    chk("prio0_idle_write_sel", bus0.rf_data_in_sel, 3'd7);
    step();
    bus0.byte_wr_valid = 1'b0;
    @(negedge clk);
    chk("prio0_A", rf0[7], 8'h55);
    chk("prio0_E", rf0[3], 8'h01);
    chk("prio0_D", rf0[2], 8'h00);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
